// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Op-code encoding of the shared ALU. The same constants are used by the ALU
// datapath, the arbiter top and the control decoder.
//
// Contents:
//   NB_ALU_OP   width of the op-code field
//   NB_SHAMT    width of the shift-amount field
//   OP_*        supported op codes (R-type funct values, I-type opcodes)
//   OP_IDLE     idle/bubble code, not a legal ALU operation
//   is_legal_op returns 1 when an op code belongs to the supported set
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int NB_ALU_OP = 6;
    localparam int NB_SHAMT  = 5;

    // R-type (funct field)
    localparam logic [NB_ALU_OP-1:0] OP_SLL   = 6'b000000;
    localparam logic [NB_ALU_OP-1:0] OP_SRL   = 6'b000010;
    localparam logic [NB_ALU_OP-1:0] OP_SRA   = 6'b000011;
    localparam logic [NB_ALU_OP-1:0] OP_SLLV  = 6'b000100;
    localparam logic [NB_ALU_OP-1:0] OP_SRLV  = 6'b000110;
    localparam logic [NB_ALU_OP-1:0] OP_SRAV  = 6'b000111;
    localparam logic [NB_ALU_OP-1:0] OP_ADD   = 6'b100000;
    localparam logic [NB_ALU_OP-1:0] OP_ADDU  = 6'b100001;
    localparam logic [NB_ALU_OP-1:0] OP_SUB   = 6'b100010;
    localparam logic [NB_ALU_OP-1:0] OP_SUBU  = 6'b100011;
    localparam logic [NB_ALU_OP-1:0] OP_AND   = 6'b100100;
    localparam logic [NB_ALU_OP-1:0] OP_OR    = 6'b100101;
    localparam logic [NB_ALU_OP-1:0] OP_XOR   = 6'b100110;
    localparam logic [NB_ALU_OP-1:0] OP_NOR   = 6'b100111;
    localparam logic [NB_ALU_OP-1:0] OP_SLT   = 6'b101010;
    localparam logic [NB_ALU_OP-1:0] OP_SLTU  = 6'b101011;

    // I-type (opcode field); operand B carries the already-extended immediate
    localparam logic [NB_ALU_OP-1:0] OP_ADDI  = 6'b001000;
    localparam logic [NB_ALU_OP-1:0] OP_ADDIU = 6'b001001;
    localparam logic [NB_ALU_OP-1:0] OP_SLTI  = 6'b001010;
    localparam logic [NB_ALU_OP-1:0] OP_SLTIU = 6'b001011;
    localparam logic [NB_ALU_OP-1:0] OP_ANDI  = 6'b001100;
    localparam logic [NB_ALU_OP-1:0] OP_ORI   = 6'b001101;
    localparam logic [NB_ALU_OP-1:0] OP_XORI  = 6'b001110;
    localparam logic [NB_ALU_OP-1:0] OP_LUI   = 6'b001111;

    localparam logic [NB_ALU_OP-1:0] OP_IDLE  = 6'b111111;

    function automatic logic is_legal_op(input logic [NB_ALU_OP-1:0] op);
        logic legal;
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// alu_rr_arbiter
// Combinational round-robin grant: scans the request vector starting at the
// pointer and grants the first requester found.
//
// Optional feature macro: ALU_ARB_LOCK_EN (adds i_lock; a locked grantee keeps
// the pointer so it wins again next cycle if it still requests).
//
// Ports:
//   i_req       request vector (already masked by flush/reset in the top)
//   i_ptr       current round-robin pointer
//   i_lock      per-requester lock (ALU_ARB_LOCK_EN only)
//   o_gnt       one-hot or zero grant
//   o_next_ptr  pointer value to load when o_gnt is non-zero
// ----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int NB_REQ = 2,
    parameter int NB_TAG = 1
) (
    input  logic [NB_REQ-1:0] i_req,
    input  logic [NB_TAG-1:0] i_ptr,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NB_REQ-1:0] i_lock,
`endif
    output logic [NB_REQ-1:0] o_gnt,
    output logic [NB_TAG-1:0] o_next_ptr
);

    int   scan_idx;
    logic found;

    always_comb begin
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        found      = 1'b0;
        scan_idx   = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            scan_idx = (int'(i_ptr) + i) % NB_REQ;
            if (!found && i_req[scan_idx]) begin
                found           = 1'b1;
                o_gnt[scan_idx] = 1'b1;
                o_next_ptr      = NB_TAG'((scan_idx + 1) % NB_REQ);
`ifdef ALU_ARB_LOCK_EN
                // Locked grantee parks the pointer on itself.
                if (i_lock[scan_idx]) begin
                    o_next_ptr = NB_TAG'(scan_idx);
                end
`endif
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU among NB_REQ requesters by round-robin. An accepted op is
// captured in S1 (operand register), evaluated by the ALU, and registered in
// S2 (result register); the result returns two cycles after the grant.
//
// Optional feature macro: ALU_ARB_LOCK_EN (adds i_lock, grant hold).
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req               per-requester request, operands valid while high
//   i_op/i_data_A/B     per-requester op code and signed operands (packed)
//   i_shamt             per-requester shift amount
//   i_flush             kill in-flight ops, block grants this cycle
//   i_lock              (ALU_ARB_LOCK_EN) hold grant for the next op
//   o_gnt               combinational one-hot grant
//   o_valid             one-hot result-valid pulse, indexed by issuer
//   o_result            registered ALU result
//   o_illegal           qualifies o_valid: op code unsupported, result 0
//   o_busy              S1 or S2 holds a live op
//
// Handshake: a requester holds i_req and its operands until it observes
// o_gnt[k]=1; the operands are sampled on that clock edge. Lowering i_req
// before a grant withdraws the request. Results are never back-pressured.
// ----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6,
    parameter int NB_REQ  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NB_REQ-1:0]         i_req,
    input  logic [NB_REQ*NB_OP-1:0]   i_op,
    input  logic [NB_REQ*NB_DATA-1:0] i_data_A,
    input  logic [NB_REQ*NB_DATA-1:0] i_data_B,
    input  logic [NB_REQ*NB_SHAMT-1:0] i_shamt,
    input  logic                      i_flush,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NB_REQ-1:0]         i_lock,
`endif
    output logic [NB_REQ-1:0]         o_gnt,
    output logic [NB_REQ-1:0]         o_valid,
    output logic [NB_DATA-1:0]        o_result,
    output logic                      o_illegal,
    output logic                      o_busy
);

    localparam int NB_TAG = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    // Arbitration
    logic [NB_TAG-1:0] rr_ptr_q, rr_ptr_d;
    logic [NB_TAG-1:0] arb_next_ptr;
    logic [NB_REQ-1:0] req_masked;
    logic [NB_REQ-1:0] arb_gnt;
    logic [NB_TAG-1:0] gnt_idx;

    // S1: operand register
    logic               s1_valid_q, s1_valid_d;
    logic [NB_OP-1:0]   s1_op_q, s1_op_d;
    logic [NB_DATA-1:0] s1_a_q, s1_a_d;
    logic [NB_DATA-1:0] s1_b_q, s1_b_d;
    logic [NB_SHAMT-1:0] s1_shamt_q, s1_shamt_d;
    logic [NB_TAG-1:0]  s1_tag_q, s1_tag_d;

    // S2: result register
    logic               s2_valid_q, s2_valid_d;
    logic [NB_DATA-1:0] s2_result_q, s2_result_d;
    logic               s2_illegal_q, s2_illegal_d;
    logic [NB_TAG-1:0]  s2_tag_q, s2_tag_d;

    // ALU
    logic [NB_DATA-1:0] alu_result;
    logic               alu_illegal;
    logic               signed_lt;
    logic               unsigned_lt;

    // Flush and reset both block new grants; the pointer then holds.
    assign req_masked = (i_reset || i_flush) ? '0 : i_req;

    alu_rr_arbiter #(
        .NB_REQ (NB_REQ),
        .NB_TAG (NB_TAG)
    ) u_rr_arbiter (
        .i_req      (req_masked),
        .i_ptr      (rr_ptr_q),
`ifdef ALU_ARB_LOCK_EN
        .i_lock     (i_lock),
`endif
        .o_gnt      (arb_gnt),
        .o_next_ptr (arb_next_ptr)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = NB_TAG'(i);
            end
        end
    end

    // ALU: purely combinational on S1. Unsupported codes yield 0 rather than
    // holding a previous value.
    assign signed_lt   = $signed(s1_a_q) < $signed(s1_b_q);
    assign unsigned_lt = s1_a_q < s1_b_q;

    always_comb begin
        alu_result  = '0;
        alu_illegal = !is_legal_op(s1_op_q);
        case (s1_op_q)
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: alu_result = s1_a_q + s1_b_q;
            OP_SUB, OP_SUBU:                    alu_result = s1_a_q - s1_b_q;
            OP_AND, OP_ANDI:                    alu_result = s1_a_q & s1_b_q;
            OP_OR,  OP_ORI:                     alu_result = s1_a_q | s1_b_q;
            OP_XOR, OP_XORI:                    alu_result = s1_a_q ^ s1_b_q;
            OP_NOR:                             alu_result = ~(s1_a_q | s1_b_q);
            OP_SLT, OP_SLTI:                    alu_result = {{(NB_DATA-1){1'b0}}, signed_lt};
            OP_SLTU, OP_SLTIU:                  alu_result = {{(NB_DATA-1){1'b0}}, unsigned_lt};
            OP_SLL:                             alu_result = s1_b_q << s1_shamt_q;
            OP_SRL:                             alu_result = s1_b_q >> s1_shamt_q;
            OP_SRA:                             alu_result = $signed(s1_b_q) >>> s1_shamt_q;
            // Variable shifts take the amount from A[4:0].
            OP_SLLV:                            alu_result = s1_b_q << s1_a_q[NB_SHAMT-1:0];
            OP_SRLV:                            alu_result = s1_b_q >> s1_a_q[NB_SHAMT-1:0];
            OP_SRAV:                            alu_result = $signed(s1_b_q) >>> s1_a_q[NB_SHAMT-1:0];
            OP_LUI:                             alu_result = s1_b_q << 16;
            default:                            alu_result = '0;
        endcase
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = |arb_gnt;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_shamt_d = s1_shamt_q;
        s1_tag_d   = s1_tag_q;

        if (|arb_gnt) begin
            rr_ptr_d   = arb_next_ptr;
            s1_op_d    = i_op[int'(gnt_idx)*NB_OP +: NB_OP];
            s1_a_d     = i_data_A[int'(gnt_idx)*NB_DATA +: NB_DATA];
            s1_b_d     = i_data_B[int'(gnt_idx)*NB_DATA +: NB_DATA];
            s1_shamt_d = i_shamt[int'(gnt_idx)*NB_SHAMT +: NB_SHAMT];
            s1_tag_d   = gnt_idx;
        end

        // A flush kills the op leaving S1; the one already in S2 has been
        // presented this cycle and simply retires.
        s2_valid_d   = s1_valid_q && !i_flush;
        s2_result_d  = s2_result_q;
        s2_illegal_d = s2_illegal_q;
        s2_tag_d     = s2_tag_q;
        if (s1_valid_q && !i_flush) begin
            s2_result_d  = alu_illegal ? '0 : alu_result;
            s2_illegal_d = alu_illegal;
            s2_tag_d     = s1_tag_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_IDLE[NB_OP-1:0];
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_shamt_q   <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_illegal_q <= 1'b0;
            s2_tag_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_shamt_q   <= s1_shamt_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_illegal_q <= s2_illegal_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    always_comb begin
        o_valid = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            o_valid[i] = s2_valid_q && (s2_tag_q == NB_TAG'(i));
        end
    end

    assign o_gnt     = arb_gnt;
    assign o_result  = s2_result_q;
    assign o_illegal = s2_valid_q && s2_illegal_q;
    assign o_busy    = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Bench for alu_share_arbiter with NB_DATA=32, NB_OP=6, NB_REQ=2. A grant
// tracker predicts grants and pushes expected results into exp_q; a separate
// monitor pops and compares whenever a result is due or o_valid appears.
// Build with ALU_ARB_LOCK_EN defined to also exercise the lock feature.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NB_DATA = 32;
    localparam int NB_OP   = 6;
    localparam int NB_REQ  = 2;

    typedef struct packed {
        logic [31:0] due;
        logic        tag;
        logic        ill;
        logic [31:0] res;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  op_r [2];
    logic [31:0] a_r  [2];
    logic [31:0] b_r  [2];
    logic [4:0]  sh_r [2];
    logic        flush;
    logic [1:0]  lock;
    logic [11:0] op_flat;
    logic [63:0] a_flat;
    logic [63:0] b_flat;
    logic [9:0]  sh_flat;
    logic [1:0]  o_gnt;
    logic [1:0]  o_valid;
    logic [31:0] o_result;
    logic        o_illegal;
    logic        o_busy;

    exp_t        exp_q[$];
    int          n_checks;
    int          n_errors;
    logic [31:0] cyc;
    int          ptr_m;
    logic        rst_prev;
    logic [1:0]  last_gnt;

    logic [5:0] legal_ops [24] = '{
        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b001000, 6'b001001,
        6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111
    };

    assign op_flat = {op_r[1], op_r[0]};
    assign a_flat  = {a_r[1], a_r[0]};
    assign b_flat  = {b_r[1], b_r[0]};
    assign sh_flat = {sh_r[1], sh_r[0]};

    alu_share_arbiter #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP),
        .NB_REQ  (NB_REQ)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_req     (req),
        .i_op      (op_flat),
        .i_data_A  (a_flat),
        .i_data_B  (b_flat),
        .i_shamt   (sh_flat),
        .i_flush   (flush),
`ifdef ALU_ARB_LOCK_EN
        .i_lock    (lock),
`endif
        .o_gnt     (o_gnt),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_illegal (o_illegal),
        .o_busy    (o_busy)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {illegal, result} straight from the instruction-set meaning.
    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        ill;
        ill = 1'b0;
        case (op)
            6'b100000, 6'b100001, 6'b001000, 6'b001001: r = a + b;
            6'b100010, 6'b100011: r = a - b;
            6'b100100, 6'b001100: r = a & b;
            6'b100101, 6'b001101: r = a | b;
            6'b100110, 6'b001110: r = a ^ b;
            6'b100111:            r = ~(a | b);
            6'b101010, 6'b001010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'b101011, 6'b001011: r = (a < b) ? 32'd1 : 32'd0;
            6'b000000:            r = b << sh;
            6'b000010:            r = b >> sh;
            6'b000011:            r = $signed(b) >>> sh;
            6'b000100:            r = b << a[4:0];
            6'b000110:            r = b >> a[4:0];
            6'b000111:            r = $signed(b) >>> a[4:0];
            6'b001111:            r = {b[15:0], 16'h0000};
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
        return {ill, r};
    endfunction

    function automatic logic lock_of(input int k);
`ifdef ALU_ARB_LOCK_EN
        return lock[k];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- grant tracker (issues expectations) ----------------
    initial begin
        ptr_m    = 0;
        rst_prev = 1'b0;
        last_gnt = 2'b00;
    end

    always @(negedge clk) begin
        logic [1:0]  g_exp;
        logic        busy_exp;
        logic        found;
        int          k;
        int          gk;
        logic [32:0] r;
        exp_t        e;

        busy_exp = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i].due == cyc || exp_q[i].due == cyc + 1) busy_exp = 1'b1;
        end
        check("busy", {63'd0, o_busy}, {63'd0, busy_exp});

        if (rst_prev) begin
            check("post_reset_valid", {62'd0, o_valid}, 64'd0);
            check("post_reset_result", {32'd0, o_result}, 64'd0);
            check("post_reset_illegal", {63'd0, o_illegal}, 64'd0);
        end

        g_exp = 2'b00;
        found = 1'b0;
        gk    = 0;
        if (!rst && !flush) begin
            for (int i = 0; i < 2; i++) begin
                k = (ptr_m + i) % 2;
                if (!found && req[k]) begin
                    found    = 1'b1;
                    gk       = k;
                    g_exp[k] = 1'b1;
                end
            end
        end
        check("gnt", {62'd0, o_gnt}, {62'd0, g_exp});

        if (rst || flush) begin
            while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
            if (rst) ptr_m = 0;
        end else if (found) begin
            r     = ref_alu(op_r[gk], a_r[gk], b_r[gk], sh_r[gk]);
            e.due = cyc + 2;
            e.tag = gk[0];
            e.ill = r[32];
            e.res = r[31:0];
            exp_q.push_back(e);
            ptr_m = lock_of(gk) ? gk : (gk + 1) % 2;
        end

        last_gnt = o_gnt;
        rst_prev = rst;
    end

    // ---------------- monitor (pops and compares) ----------------
    always @(negedge clk) begin
        exp_t e;
        #2;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            check("missed_result", 64'd0, 64'd1);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("valid", {62'd0, o_valid}, {62'd0, (e.tag ? 2'b10 : 2'b01)});
            check("result", {32'd0, o_result}, {32'd0, e.res});
            check("illegal", {63'd0, o_illegal}, {63'd0, e.ill});
        end else if (o_valid != 2'b00) begin
            check("unexpected_valid", {62'd0, o_valid}, 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #3;
    endtask

    task automatic clear_inputs();
        req   = 2'b00;
        flush = 1'b0;
        lock  = 2'b00;
        for (int k = 0; k < 2; k++) begin
            op_r[k] = 6'b111111;
            a_r[k]  = '0;
            b_r[k]  = '0;
            sh_r[k] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic set_op(input int k, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        op_r[k] = op;
        a_r[k]  = a;
        b_r[k]  = b;
        sh_r[k] = sh;
    endtask

    task automatic set_rand_op(input int k);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom();
        b = $urandom();
        case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: b = 32'h8000_0000;
            2: a = 32'h0000_0000;
            default: ;
        endcase
        set_op(k, ($urandom_range(0, 9) == 0) ? 6'($urandom()) : legal_ops[$urandom_range(0, 23)],
               a, b, 5'($urandom()));
    endtask

    // Single op from requester k with no competitor; checks the result
    // two cycles after the grant against a constant.
    task automatic single_op(input string name, input int k, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_ill);
        req[k] = 1'b1;
        set_op(k, op, a, b, 5'd0);
        at_sample();
        check({name, "_gnt"}, {62'd0, o_gnt}, (k == 0) ? 64'd1 : 64'd2);
        step();
        req[k] = 1'b0;
        step();
        at_sample();
        check({name, "_valid"}, {62'd0, o_valid}, (k == 0) ? 64'd1 : 64'd2);
        check({name, "_result"}, {32'd0, o_result}, {32'd0, exp_res});
        check({name, "_illegal"}, {63'd0, o_illegal}, {63'd0, exp_ill});
        step();
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k] && last_gnt[k]) req[k] = 1'b0;
                if (!req[k]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req[k] = 1'b1;
                        set_rand_op(k);
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    req[k] = 1'b0;
                end
            end
            flush = ($urandom_range(0, 99) < 6);
            lock  = 2'($urandom());
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst   = 1'b0;
        flush = 1'b0;
        lock  = 2'b00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        rst = 1'b1;
        step();
        at_sample();
        check("reset_valid", {62'd0, o_valid}, 64'd0);
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check("reset_result", {32'd0, o_result}, 64'd0);
        check("reset_illegal", {63'd0, o_illegal}, 64'd0);
        do_reset();

        // 1: add 5+7 from requester 0
        single_op("add_5_7", 0, 6'b100000, 32'd5, 32'd7, 32'd12, 1'b0);

        // 2: both requesters held, alternating grants
        do_reset();
        req = 2'b11;
        set_rand_op(0);
        set_rand_op(1);
        for (int c = 0; c < 4; c++) begin
            at_sample();
            check("rr_alternate", {62'd0, o_gnt}, (c % 2 == 0) ? 64'd1 : 64'd2);
            step();
            if (last_gnt[0]) set_rand_op(0);
            if (last_gnt[1]) set_rand_op(1);
        end
        req = 2'b00;
        repeat (3) step();

        // 3: flush the op issued by requester 1
        req[1] = 1'b1;
        set_op(1, 6'b100010, 32'd3, 32'd5, 5'd0);
        at_sample();
        check("flush_issue_gnt", {62'd0, o_gnt}, 64'd2);
        step();
        req[1] = 1'b0;
        flush  = 1'b1;
        step();
        flush  = 1'b0;
        at_sample();
        check("flush_busy", {63'd0, o_busy}, 64'd0);
        check("flush_no_valid", {62'd0, o_valid}, 64'd0);
        step();

        // 4: illegal code, idle code, signed/unsigned compare
        single_op("illegal_010000", 0, 6'b010000, 32'd1, 32'd1, 32'd0, 1'b1);
        single_op("idle_op", 1, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b1);
        single_op("sltu_m1_1", 0, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        single_op("slt_m1_1", 1, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        single_op("sra_var", 0, 6'b000111, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0);

        // 5: reset one cycle after a grant
        req[0] = 1'b1;
        set_op(0, 6'b100000, 32'd100, 32'd200, 5'd0);
        step();
        req[0] = 1'b0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        req    = 2'b11;
        set_rand_op(0);
        set_rand_op(1);
        at_sample();
        check("midreset_gnt_req0", {62'd0, o_gnt}, 64'd1);
        check("midreset_result", {32'd0, o_result}, 64'd0);
        check("midreset_busy", {63'd0, o_busy}, 64'd0);
        step();
        req = 2'b00;
        repeat (3) step();

`ifdef ALU_ARB_LOCK_EN
        // 6: locked requester 0 keeps winning
        do_reset();
        step();
        req  = 2'b11;
        lock = 2'b01;
        set_rand_op(0);
        set_rand_op(1);
        for (int c = 0; c < 3; c++) begin
            at_sample();
            check("lock_hold", {62'd0, o_gnt}, 64'd1);
            step();
            set_rand_op(0);
        end
        lock   = 2'b00;
        req[0] = 1'b0;
        at_sample();
        check("lock_release", {62'd0, o_gnt}, 64'd2);
        step();
        req = 2'b00;
        repeat (3) step();
`endif

        // Random traffic against the model
        rand_cycles(400);
        req = 2'b00;
        repeat (5) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
